// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, encodings and helpers for the pipeline controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FREEZE   = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_wen;
    logic       mem_ren;
  } ex_shadow_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wen;
  } late_shadow_t;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value
  function automatic logic fwd_hit(late_shadow_t s, logic [4:0] src);
    return s.valid & s.reg_wen & (s.rd != 5'd0) & (s.rd == src);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - decode/hazard inputs and pipeline control outputs of the controller
interface pipeline_ctrl_if;

  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_uses_rs2_i;
  logic        id_reg_wen_i;
  logic        id_mem_ren_i;
  logic        ex_redirect_i;
  logic        icache_stall_i;
  logic        dcache_stall_i;

  logic        pc_en_o;
  logic        pc_sel_o;
  logic        ifid_en_o;
  logic        ifid_flush_o;
  logic        idex_en_o;
  logic        idex_flush_o;
  logic        exmem_en_o;
  logic        memwb_en_o;
  logic [1:0]  fwd_a_o;
  logic [1:0]  fwd_b_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs2_i,
    output id_reg_wen_i, id_mem_ren_i, ex_redirect_i, icache_stall_i, dcache_stall_i,
    input  pc_en_o, pc_sel_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
    input  exmem_en_o, memwb_en_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs2_i,
    input  id_reg_wen_i, id_mem_ren_i, ex_redirect_i, icache_stall_i, dcache_stall_i,
    output pc_en_o, pc_sel_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
    output exmem_en_o, memwb_en_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand bypass select for one EX source register, MEM result preferred over WB
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  late_shadow_t mem_i,
  input  late_shadow_t wb_i,
  input  logic [4:0]   src_i,
  output logic [1:0]   sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (fwd_hit(mem_i, src_i)) begin
      sel_o = FWD_MEM;
    end else if (fwd_hit(wb_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline hazard controller: freeze, redirect, load-use stall and forwarding
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  ctrl_state_e  state_q, state_d;
  ex_shadow_t   ex_q, ex_d;
  late_shadow_t mem_q, mem_d;
  late_shadow_t wb_q, wb_d;
  logic [31:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0]  flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic redirect;
  logic hazard;
  logic lu_stall;

  logic pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  always_comb begin
    mem_stall = bus.icache_stall_i | bus.dcache_stall_i;
    redirect  = bus.ex_redirect_i & ~mem_stall;
    hazard    = bus.id_valid_i & ex_q.valid & ex_q.mem_ren & (ex_q.rd != 5'd0) &
                ((ex_q.rd == bus.id_rs1_i) | (bus.id_uses_rs2_i & (ex_q.rd == bus.id_rs2_i)));
    // a redirect flushes the dependent ID instruction, so the stall would be wasted
    lu_stall  = hazard & ~mem_stall & ~bus.ex_redirect_i & (state_q != ST_LU_STALL);
  end

  always_comb begin
    pc_en      = 1'b1;
    pc_sel     = 1'b0;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_en    = 1'b0;
      idex_flush = 1'b1;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
    end else if (mem_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (redirect) begin
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mem_stall) begin
      state_d = ST_FREEZE;
    end else begin
      case (state_q)
        ST_RUN:      state_d = lu_stall ? ST_LU_STALL : ST_RUN;
        ST_LU_STALL: state_d = ST_RUN;
        ST_FREEZE:   state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (idex_en) begin
      ex_d.valid   = bus.id_valid_i & ~idex_flush;
      ex_d.rs1     = bus.id_rs1_i;
      ex_d.rs2     = bus.id_rs2_i;
      ex_d.rd      = bus.id_rd_i;
      ex_d.reg_wen = bus.id_reg_wen_i;
      ex_d.mem_ren = bus.id_mem_ren_i;
    end
    if (exmem_en) begin
      mem_d.valid   = ex_q.valid;
      mem_d.rd      = ex_q.rd;
      mem_d.reg_wen = ex_q.reg_wen;
    end
    if (memwb_en) begin
      wb_d = mem_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, mem_stall | lu_stall};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_unit u_fwd_a (
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .src_i (ex_q.rs1),
    .sel_o (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .src_i (ex_q.rs2),
    .sel_o (fwd_b_raw)
  );

  assign bus.pc_en_o      = pc_en;
  assign bus.pc_sel_o     = pc_sel;
  assign bus.ifid_en_o    = ifid_en;
  assign bus.ifid_flush_o = ifid_flush;
  assign bus.idex_en_o    = idex_en;
  assign bus.idex_flush_o = idex_flush;
  assign bus.exmem_en_o   = exmem_en;
  assign bus.memwb_en_o   = memwb_en;
  assign bus.fwd_a_o      = rst_n ? fwd_a_raw : FWD_RF;
  assign bus.fwd_b_o      = rst_n ? fwd_b_raw : FWD_RF;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  // control vector order: pc_en pc_sel ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en
  localparam logic [7:0] C_RESET = 8'b0001_0100;
  localparam logic [7:0] C_RUN   = 8'b1010_1011;
  localparam logic [7:0] C_LU    = 8'b0000_1111;
  localparam logic [7:0] C_REDIR = 8'b1111_1111;
  localparam logic [7:0] C_FRZ   = 8'b0000_0000;

  pipeline_ctrl_if bus();

  pipeline_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {bus.pc_en_o, bus.pc_sel_o, bus.ifid_en_o, bus.ifid_flush_o,
            bus.idex_en_o, bus.idex_flush_o, bus.exmem_en_o, bus.memwb_en_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic uses2, input logic wen,
                        input logic mren);
    bus.id_valid_i    = v;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_rd_i       = rd;
    bus.id_uses_rs2_i = uses2;
    bus.id_reg_wen_i  = wen;
    bus.id_mem_ren_i  = mren;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.ex_redirect_i  = 1'b0;
    bus.icache_stall_i = 1'b0;
    bus.dcache_stall_i = 1'b0;
    tick();
    tick();
    chk("reset_ctl", {24'd0, ctl()}, {24'd0, C_RESET});
    chk("reset_stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("reset_flush_cnt", bus.flush_cnt_o, 32'd0);
    chk("reset_fwd", {28'd0, bus.fwd_a_o, bus.fwd_b_o}, 32'd0);

    // load-use: LW x5 then ADD x6,x5,x1
    rst_n = 1'b1;
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
    #1;
    chk("run_ctl", {24'd0, ctl()}, {24'd0, C_RUN});
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0);
    #1;
    chk("lu_ctl", {24'd0, ctl()}, {24'd0, C_LU});
    tick();
    #1;
    chk("lu_one_cycle", {24'd0, ctl()}, {24'd0, C_RUN});
    chk("lu_stall_cnt", bus.stall_cnt_o, 32'd1);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_fwd_a_wb", {30'd0, bus.fwd_a_o}, 32'd2);
    chk("lu_fwd_b_rf", {30'd0, bus.fwd_b_o}, 32'd0);
    tick();

    // back-to-back ALU: ADD x3 then SUB x7,x4,x3
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    #1;
    chk("alu_fwd_b_mem", {30'd0, bus.fwd_b_o}, 32'd1);
    chk("alu_fwd_a_rf", {30'd0, bus.fwd_a_o}, 32'd0);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("alu_mem_wins_b", {30'd0, bus.fwd_b_o}, 32'd1);
    chk("alu_mem_wins_a", {30'd0, bus.fwd_a_o}, 32'd1);
    chk("alu_no_stall_cnt", bus.stall_cnt_o, 32'd1);

    // redirect coincident with a load-use hazard
    do_reset();
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0);
    bus.ex_redirect_i = 1'b1;
    #1;
    chk("redir_lu_ctl", {24'd0, ctl()}, {24'd0, C_REDIR});
    tick();
    bus.ex_redirect_i = 1'b0;
    #1;
    chk("redir_flush_cnt", bus.flush_cnt_o, 32'd1);
    chk("redir_stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("redir_after_ctl", {24'd0, ctl()}, {24'd0, C_RUN});

    // freeze with a pending redirect
    do_reset();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.dcache_stall_i = 1'b1;
    bus.ex_redirect_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("freeze_ctl", {24'd0, ctl()}, {24'd0, C_FRZ});
      chk("freeze_stall_cnt_progress", bus.stall_cnt_o, 32'(i));
      tick();
    end
    bus.dcache_stall_i = 1'b0;
    #1;
    chk("unfreeze_redirect_ctl", {24'd0, ctl()}, {24'd0, C_REDIR});
    chk("freeze_stall_cnt", bus.stall_cnt_o, 32'd3);
    chk("freeze_flush_cnt_held", bus.flush_cnt_o, 32'd0);
    tick();
    bus.ex_redirect_i = 1'b0;
    #1;
    chk("unfreeze_flush_cnt", bus.flush_cnt_o, 32'd1);

    // memory stall outranks load-use; the hazard survives the freeze
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0);
    bus.icache_stall_i = 1'b1;
    #1;
    chk("istall_over_lu_ctl", {24'd0, ctl()}, {24'd0, C_FRZ});
    tick();
    bus.icache_stall_i = 1'b0;
    #1;
    chk("lu_after_freeze_ctl", {24'd0, ctl()}, {24'd0, C_LU});
    chk("istall_cnt", bus.stall_cnt_o, 32'd4);
    tick();
    #1;
    chk("lu_after_freeze_cnt", bus.stall_cnt_o, 32'd5);

    // LW x0 then ADD rs1=x0: no hazard, no forward
    do_reset();
    set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0);
    #1;
    chk("x0_no_stall_ctl", {24'd0, ctl()}, {24'd0, C_RUN});
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("x0_fwd_a", {30'd0, bus.fwd_a_o}, 32'd0);
    chk("x0_stall_cnt", bus.stall_cnt_o, 32'd0);

    // reset in the middle of a freeze
    bus.dcache_stall_i = 1'b1;
    tick();
    tick();
    chk("pre_reset_stall_cnt", bus.stall_cnt_o, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midfreeze_reset_ctl", {24'd0, ctl()}, {24'd0, C_RESET});
    tick();
    chk("midfreeze_reset_stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("midfreeze_reset_flush_cnt", bus.flush_cnt_o, 32'd0);
    rst_n = 1'b1;
    bus.dcache_stall_i = 1'b0;
    #1;
    chk("post_reset_ctl", {24'd0, ctl()}, {24'd0, C_RUN});
    tick();
    chk("post_reset_stall_cnt", bus.stall_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL use one clock `clk`; reset `rst_n` is synchronous and active-low.
REQ-002 Ports SHALL be:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset.
- `id_valid_i` in 1: the ID stage holds a real instruction.
- `id_rs1_i` in 5 and `id_rs2_i` in 5: decoded source registers.
- `id_rd_i` in 5: decoded destination register.
- `id_uses_rs2_i` in 1: the ID instruction reads rs2 (OP, STORE, BRANCH).
- `id_reg_wen_i` in 1 and `id_mem_ren_i` in 1: decoded write-back and load flags.
- `ex_redirect_i` in 1: EX resolved a taken branch, JAL or JALR.
- `icache_stall_i` in 1 and `dcache_stall_i` in 1: memory not ready.
- `pc_en_o` out 1: PC update enable.
- `pc_sel_o` out 1: 1 selects the redirect target.
- `ifid_en_o` out 1 and `ifid_flush_o` out 1: IF/ID register control.
- `idex_en_o` out 1 and `idex_flush_o` out 1: ID/EX register control.
- `exmem_en_o` out 1 and `memwb_en_o` out 1: later stage enables.
- `fwd_a_o` out 2 and `fwd_b_o` out 2: EX operand source select.
- `stall_cnt_o` out 32: count of stall cycles.
- `flush_cnt_o` out 32: count of redirects.

Function
REQ-003 SHALL keep shadow pipeline registers for EX (valid, rs1, rs2, rd, reg_wen, mem_ren) and for MEM and WB (valid, rd, reg_wen), updated only when the matching stage enable is 1.
REQ-004 SHALL implement FSM states RUN, LU_STALL and FREEZE, encoded in the package.
REQ-005 FSM transitions:
- Any state goes to FREEZE when (icache_stall_i | dcache_stall_i).
- FREEZE goes to RUN when both stalls are 0.
- RUN goes to LU_STALL when a load-use hazard exists and there is no redirect.
- LU_STALL goes to RUN after exactly one cycle.
REQ-006 Load-use hazard: id_valid_i & EX.valid & EX.mem_ren & EX.rd!=0 & (EX.rd==id_rs1_i | (id_uses_rs2_i & EX.rd==id_rs2_i)).
REQ-007 FREEZE (and any cycle in which either stall input is 1) SHALL drive:
- all enables to 0;
- all flushes to 0;
- pc_sel_o to 0;
- counters do not change, except stall_cnt_o increments.
REQ-008 Load-use cycle SHALL drive:
- pc_en_o=0 and ifid_en_o=0;
- idex_en_o=1 with idex_flush_o=1, inserting a bubble;
- exmem_en_o=1 and memwb_en_o=1;
- stall_cnt_o increments by 1.
REQ-009 Redirect cycle (ex_redirect_i=1 with no memory stall) SHALL drive:
- pc_sel_o=1 and pc_en_o=1;
- ifid_flush_o=1 and idex_flush_o=1;
- all enables to 1;
- flush_cnt_o increments by 1.
REQ-010 Priority SHALL be memory stall > redirect > load-use.
- A redirect during a freeze takes effect in the first unfrozen cycle; ex_redirect_i stays asserted because EX is held.
- A redirect coincident with a load-use hazard suppresses the stall, because the ID instruction is flushed.
REQ-011 Normal RUN cycle SHALL drive all enables to 1, all flushes to 0, and pc_sel_o to 0.
REQ-012 Forwarding select for operand A SHALL be:
- 2'b01 when MEM.valid & MEM.reg_wen & MEM.rd!=0 & MEM.rd==EX.rs1;
- otherwise 2'b10 when the same conditions hold for WB;
- otherwise 2'b00.
REQ-013 fwd_b_o SHALL be computed the same way using EX.rs2.
REQ-014 Flushed or bubbled slots SHALL clear the corresponding shadow valid bit, so they never create a hazard or a forward.
REQ-015 Outputs SHALL be combinational from the state, the shadow registers and the inputs. Counters SHALL be registered and wrap modulo 2^32 with no saturation.

Reset
REQ-016 While rst_n=0 at a clock edge, the block SHALL clear:
- the state to RUN;
- all shadow valid bits to 0;
- stall_cnt_o and flush_cnt_o to 0.
REQ-017 In any cycle in which rst_n=0, outputs SHALL be:
- pc_en_o=0, pc_sel_o=0;
- all stage enables 0;
- ifid_flush_o=1 and idex_flush_o=1;
- fwd_a_o=fwd_b_o=2'b00.
REQ-018 Reset asserted mid-stall or mid-redirect SHALL override all other behaviour in that cycle. In the first cycle after release the block SHALL be in RUN and issue no stall.

Structure
REQ-019 Package pipe_ctrl_pkg SHALL hold:
- the FSM state encodings;
- FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
REQ-020 Forwarding comparison SHALL live in the combinational sub-module fwd_unit, instantiated once per operand.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load-use: LW x5 in EX, ID ADD x6,x5,x1 -> exactly 1 cycle of pc_en_o=0 and idex_flush_o=1; next cycle fwd_a_o=2'b10 when the ADD reaches EX; stall_cnt_o=1.
- Back-to-back ALU: ADD x3 in MEM, SUB in EX with rs2=x3 -> fwd_b_o=2'b01. Repeat with x3 also in WB -> still 2'b01 (MEM wins).
- Redirect plus load-use: ex_redirect_i=1 with a load-use hazard present -> pc_sel_o=1, both flushes 1, no stall; flush_cnt_o=1, stall_cnt_o=0.
- Freeze: dcache_stall_i=1 for 3 cycles with ex_redirect_i=1 -> 3 cycles with all enables 0 and pc_sel_o=0; 4th cycle pc_sel_o=1; stall_cnt_o=3.
- rd=x0: LW x0 then ADD rs1=x0 -> no stall, fwd_a_o=2'b00.
- Mid-freeze reset: rst_n=0 for 1 cycle during a freeze -> counters 0, flushes 1 during reset; first post-reset cycle all enables 1.
